// File: rtl/debug_uart_pkg.sv
// debug_uart_pkg: shared TX state type, status bit positions and baud divisor helper
package debug_uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_LEVEL_LSB = 8;

    function automatic int uart_div(input int clock_mhz, input int bit_rate);
        return clock_mhz * 1_000_000 / bit_rate;
    endfunction

endpackage

// File: rtl/debug_uart_fifo.sv
// debug_uart_fifo: synchronous show-ahead byte FIFO with push, pop, full, empty and level
module debug_uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = level == '0;
    assign full    = level == LW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // pointers wrap naturally; a pop frees a slot for a same-cycle push even when full
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // byte storage, contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/debug_uart_tx_fifo.sv
// debug_uart_tx_fifo: buffered 8N1 debug UART transmitter with status word; DEBUG_UART_TX_IRQ_EN enables the TX-empty irq
module debug_uart_tx_fifo
    import debug_uart_pkg::*;
#(
    parameter int CLOCK_MHZ  = 64,
    parameter int BIT_RATE   = 4_000_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_sel,
    input  logic [1:0]  data_write_n,
    input  logic [7:0]  data_in,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic [31:0] status_out,
    input  logic        clr_overflow,
    output logic        irq
);
    localparam int DIV = uart_div(CLOCK_MHZ, BIT_RATE);
    localparam int CW  = $clog2(DIV);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    tx_state_t     state;
    tx_state_t     state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_nx;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nx;
    logic          wr;
    logic          pop;
    logic          full;
    logic          empty;
    logic          overflow;
    logic [7:0]    fifo_dout;
    logic [LW-1:0] level;

    assign wr       = wr_sel && data_write_n != 2'b11;
    assign uart_txd = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
    assign tx_busy  = state != IDLE || !empty;

    debug_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr),
        .pop   (pop),
        .din   (data_in),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // frame sequencing: each state lasts DIV cycles, STOP chains straight into START when bytes wait
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt - 1'b1;
        bit_nx   = bit_idx;
        shreg_nx = shreg;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = RELOAD;
                if (!empty) begin
                    pop      = 1'b1;
                    shreg_nx = fifo_dout;
                    state_nx = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    cnt_nx   = RELOAD;
                    bit_nx   = '0;
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    cnt_nx   = RELOAD;
                    shreg_nx = shreg >> 1;
                    bit_nx   = bit_idx + 1'b1;
                    state_nx = bit_idx == 3'd7 ? STOP : DATA;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    cnt_nx   = RELOAD;
                    pop      = !empty;
                    shreg_nx = empty ? shreg : fifo_dout;
                    state_nx = empty ? IDLE : START;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // state, baud counter and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_nx;
            shreg   <= shreg_nx;
        end
    end

    // sticky overflow on a dropped byte; a same-cycle set beats the clear
    always_ff @(posedge clk) begin
        if (rst) overflow <= 1'b0;
        else if (wr && full && !pop) overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end

    // status word assembled from registered state
    always_comb begin
        status_out                      = '0;
        status_out[ST_BUSY]             = tx_busy;
        status_out[ST_FULL]             = full;
        status_out[ST_OVF]              = overflow;
        status_out[ST_LEVEL_LSB +: 5]   = 5'(level);
    end

`ifdef DEBUG_UART_TX_IRQ_EN
    logic irq_q;

    // raise when the line drops back to idle with nothing queued; any accepted write clears
    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else if (wr) irq_q <= 1'b0;
        else if (state != IDLE && state_nx == IDLE) irq_q <= 1'b1;
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_debug_uart_tx_fifo.sv
// tb_debug_uart_tx_fifo: directed self-checking bench for the buffered debug UART transmitter
module tb_debug_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_sel = 1'b0;
    logic [1:0]  data_write_n = 2'b11;
    logic [7:0]  data_in = 8'h00;
    logic        clr_overflow = 1'b0;
    logic        uart_txd;
    logic        tx_busy;
    logic [31:0] status_out;
    logic        irq;
    logic        irq_seen = 1'b0;
    int          checks = 0;
    int          errors = 0;

    debug_uart_tx_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .wr_sel       (wr_sel),
        .data_write_n (data_write_n),
        .data_in      (data_in),
        .uart_txd     (uart_txd),
        .tx_busy      (tx_busy),
        .status_out   (status_out),
        .clr_overflow (clr_overflow),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (irq === 1'b1) irq_seen <= 1'b1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        return k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        wr_sel = 1'b0;
        data_write_n = 2'b11;
        clr_overflow = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", uart_txd); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        checks++;
        if (status_out !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 00000000", status_out); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        wr_sel = 1'b1; data_write_n = 2'b11; data_in = 8'hFF;
        tick(1);
        wr_sel = 1'b0; data_write_n = 2'b00;
        tick(1);
        data_write_n = 2'b11;
        tick(2);
        checks++;
        if (status_out !== 32'h0 || uart_txd !== 1'b1) begin
            errors++; $display("FAIL no_write_decode: status %h txd %b want 00000000 1", status_out, uart_txd);
        end
    endtask

    task automatic test_single();
        int pos;
        do_reset();
        wr_sel = 1'b1; data_write_n = 2'b10; data_in = 8'h55;
        tick(1);
        wr_sel = 1'b0; data_write_n = 2'b11;
        checks++;
        if (status_out !== 32'h101) begin errors++; $display("FAIL single_queued: status %h want 00000101", status_out); end
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("FAIL single_pre_start: txd %b want 1", uart_txd); end
        tick(1);
        checks++;
        if (uart_txd !== 1'b0) begin errors++; $display("FAIL single_start_edge: txd %b want 0", uart_txd); end
        pos = 0;
        for (int k = 0; k < 10; k++) begin
            tick(16 * k + 8 - pos);
            pos = 16 * k + 8;
            checks++;
            if (uart_txd !== exp_bit(8'h55, k)) begin
                errors++; $display("FAIL single_bit%0d: txd %b want %b", k, uart_txd, exp_bit(8'h55, k));
            end
        end
        tick(159 - pos);
        checks++;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_last_stop_busy: got %b want 1", tx_busy); end
        tick(1);
        checks++;
        if (tx_busy !== 1'b0 || status_out[4:0] !== 5'b0 || uart_txd !== 1'b1) begin
            errors++; $display("FAIL single_done: busy %b status %h txd %b want 0 00000000 1", tx_busy, status_out, uart_txd);
        end
    endtask

    task automatic test_back_to_back();
        int pos;
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr_sel = 1'b1; data_write_n = 2'b00; data_in = 8'(8'h41 + i);
            tick(1);
        end
        wr_sel = 1'b0; data_write_n = 2'b11;
        checks++;
        if (status_out[12:8] !== 5'd2) begin errors++; $display("FAIL b2b_level_peak: got %0d want 2", status_out[12:8]); end
        pos = 1;
        for (int f = 0; f < 3; f++) begin
            b = 8'(8'h41 + f);
            for (int k = 0; k < 10; k++) begin
                tick(160 * f + 16 * k + 8 - pos);
                pos = 160 * f + 16 * k + 8;
                checks++;
                if (uart_txd !== exp_bit(b, k)) begin
                    errors++; $display("FAIL b2b_f%0d_bit%0d: txd %b want %b", f, k, uart_txd, exp_bit(b, k));
                end
            end
        end
        tick(479 - pos);
        checks++;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL b2b_last_busy: got %b want 1", tx_busy); end
        tick(1);
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_done: busy %b want 0", tx_busy); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_sel = 1'b1; data_write_n = 2'b01; data_in = 8'(i + 1);
            tick(1);
        end
        wr_sel = 1'b0; data_write_n = 2'b11;
        checks++;
        if (status_out !== 32'h807) begin errors++; $display("FAIL ovf_set: status %h want 00000807", status_out); end
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        checks++;
        if (status_out !== 32'h803) begin errors++; $display("FAIL ovf_clear: status %h want 00000803", status_out); end
        wr_sel = 1'b1; data_write_n = 2'b00; data_in = 8'hEE; clr_overflow = 1'b1;
        tick(1);
        wr_sel = 1'b0; data_write_n = 2'b11; clr_overflow = 1'b0;
        checks++;
        if (status_out !== 32'h807) begin errors++; $display("FAIL ovf_set_wins: status %h want 00000807", status_out); end
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        checks++;
        if (status_out !== 32'h803) begin errors++; $display("FAIL ovf_clear2: status %h want 00000803", status_out); end
    endtask

    task automatic test_full_pop_push();
        int pos;
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wr_sel = 1'b1; data_write_n = 2'b10; data_in = 8'(8'h10 + i);
            tick(1);
        end
        wr_sel = 1'b0; data_write_n = 2'b11;
        checks++;
        if (status_out !== 32'h803) begin errors++; $display("FAIL full_filled: status %h want 00000803", status_out); end
        tick(152);
        wr_sel = 1'b1; data_write_n = 2'b00; data_in = 8'hC3;
        tick(1);
        wr_sel = 1'b0; data_write_n = 2'b11;
        checks++;
        if (status_out !== 32'h803) begin errors++; $display("FAIL full_pop_push: status %h want 00000803", status_out); end
        pos = 160;
        for (int f = 8; f < 10; f++) begin
            b = f == 9 ? 8'hC3 : 8'h18;
            for (int k = 0; k < 10; k++) begin
                tick(160 * f + 16 * k + 8 - pos);
                pos = 160 * f + 16 * k + 8;
                checks++;
                if (uart_txd !== exp_bit(b, k)) begin
                    errors++; $display("FAIL full_f%0d_bit%0d: txd %b want %b", f, k, uart_txd, exp_bit(b, k));
                end
            end
        end
        tick(1599 - pos);
        checks++;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL full_last_busy: got %b want 1", tx_busy); end
        tick(1);
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL full_done: busy %b want 0", tx_busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic bad;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_sel = 1'b1; data_write_n = 2'b00; data_in = i == 0 ? 8'hA5 : 8'(i);
            tick(1);
        end
        wr_sel = 1'b0; data_write_n = 2'b11;
        checks++;
        if (status_out !== 32'h301) begin errors++; $display("FAIL mid_queued: status %h want 00000301", status_out); end
        tick(36);
        checks++;
        if (uart_txd !== 1'b0) begin errors++; $display("FAIL mid_data_bit1: txd %b want 0", uart_txd); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || status_out !== 32'h0) begin
            errors++; $display("FAIL mid_abort: txd %b busy %b status %h want 1 0 00000000", uart_txd, tx_busy, status_out);
        end
        bad = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL mid_no_frames: activity %b want 0", bad); end
    endtask

`ifdef DEBUG_UART_TX_IRQ_EN
    task automatic test_irq();
        do_reset();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_reset: got %b want 0", irq); end
        wr_sel = 1'b1; data_write_n = 2'b00; data_in = 8'h7E;
        tick(1);
        wr_sel = 1'b0; data_write_n = 2'b11;
        tick(160);
        checks++;
        if (irq !== 1'b0 || tx_busy !== 1'b1) begin errors++; $display("FAIL irq_in_stop: irq %b busy %b want 0 1", irq, tx_busy); end
        tick(1);
        checks++;
        if (irq !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL irq_rise: irq %b busy %b want 1 0", irq, tx_busy); end
        wr_sel = 1'b1; data_write_n = 2'b01; data_in = 8'h01;
        tick(1);
        wr_sel = 1'b0; data_write_n = 2'b11;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
        tick(161);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise2: got %b want 1", irq); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop_push();
        test_reset_mid_frame();
`ifdef DEBUG_UART_TX_IRQ_EN
        test_irq();
`else
        checks++;
        if (irq_seen !== 1'b0) begin errors++; $display("FAIL irq_tied_low: seen %b want 0", irq_seen); end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
